// File: rtl/sm83_bus_pkg.sv
// sm83_bus_pkg
// Types and constants shared by the SM83 external bus cycle sequencer.
//   tstate_t        : machine-cycle T-state encoding (IDLE, T1..T4)
//   bus_dir_t       : direction of the access in flight (RD, WR)
//   DEF_ADR_WIDTH   : default address width; matches the address latch stage
//   DEF_DATA_WIDTH  : default data width
//   req_dir()       : direction chosen for a request pair (read wins)
package sm83_bus_pkg;

  localparam int DEF_ADR_WIDTH  = 16;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4
  } tstate_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } bus_dir_t;

  // A simultaneous read and write request resolves to a read; the write is
  // dropped and the core is expected to re-issue it.
  function automatic bus_dir_t req_dir(input logic rd, input logic wr);
    bus_dir_t dir;
    if (rd)      dir = RD;
    else if (wr) dir = WR;
    else         dir = RD;
    return dir;
  endfunction

endpackage

// File: rtl/sm83_bus_ctl_if.sv
// sm83_bus_ctl_if
// Groups the core-side handshake and the external pin signals of the bus
// cycle sequencer.
//   Core side : adr_in, wdata, req_rd, req_wr -> ; <- rdata, ack, busy
//   Pin side  : a_pin, d_pin_out, d_pin_oe, rd_n, wr_n -> ; <- d_pin_in, wait_n
// Modports:
//   slave  : the bus controller (sm83_bus_ctl)
//   master : whatever drives requests and models the external bus
interface sm83_bus_ctl_if
  import sm83_bus_pkg::*;
#(
  parameter int ADR_WIDTH  = DEF_ADR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [ADR_WIDTH-1:0]  adr_in;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  req_rd;
  logic                  req_wr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;
  logic                  busy;

  logic [ADR_WIDTH-1:0]  a_pin;
  logic [DATA_WIDTH-1:0] d_pin_out;
  logic                  d_pin_oe;
  logic [DATA_WIDTH-1:0] d_pin_in;
  logic                  rd_n;
  logic                  wr_n;
  logic                  wait_n;

  modport slave (
    input  adr_in, wdata, req_rd, req_wr, d_pin_in, wait_n,
    output rdata, ack, busy, a_pin, d_pin_out, d_pin_oe, rd_n, wr_n
  );

  modport master (
    output adr_in, wdata, req_rd, req_wr, d_pin_in, wait_n,
    input  rdata, ack, busy, a_pin, d_pin_out, d_pin_oe, rd_n, wr_n
  );

endinterface

// File: rtl/sm83_bus_seq.sv
// sm83_bus_seq
// T-state sequencer for one external machine cycle.
// Ports:
//   clk     in   T-state clock
//   reset   in   synchronous active-low reset
//   req     in   any access request (read or write)
//   wait_n  in   external wait, active-low (honoured only with SM83_BUS_WAIT_EN)
//   state   out  current T-state
//   load    out  capture strobe for address/data/direction registers
//   ack     out  one-clock completion pulse, the clock after T4
// Build option: SM83_BUS_WAIT_EN enables wait-state insertion in T3.
//
// state | meaning
// IDLE  | no cycle in progress, waiting for a request
// T1    | address out, read strobe asserted for reads
// T2    | write data driven for writes
// T3    | write strobe asserted for writes; wait states extend this state
// T4    | last T-state; read data latched and next request accepted on exit
module sm83_bus_seq
  import sm83_bus_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req,
  input  logic    wait_n,
  output tstate_t state,
  output logic    load,
  output logic    ack
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       stall;

`ifdef SM83_BUS_WAIT_EN
  assign stall = ~wait_n;
`else
  logic unused_wait_n;
  assign unused_wait_n = wait_n;
  assign stall = 1'b0;
`endif

  // Requests are only accepted from IDLE or on the way out of T4, which is
  // what gives back-to-back cycles with no idle gap.
  assign load = req & ((state_q == S_IDLE) | (state_q == S_T4));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = req ? S_T1 : S_IDLE;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = stall ? S_T3 : S_T4;
      S_T4:    state_d = req ? S_T1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ack     <= 1'b0;
    end else begin
      state_q <= state_d;
      ack     <= (state_q == S_T4);
    end
  end

  assign state = tstate_t'(state_q);

endmodule

// File: rtl/sm83_bus_ctl.sv
// sm83_bus_ctl
// External bus cycle sequencer for the SM83 core. Samples the latched
// address with a read or write request, runs one 4-T-state machine cycle on
// the external pins and returns read data with a one-clock acknowledge.
// Ports:
//   clk    in  T-state clock, all updates on posedge
//   reset  in  synchronous active-low reset
//   bus    sm83_bus_ctl_if.slave
//          core side : adr_in, wdata, req_rd, req_wr / rdata, ack, busy
//          pin side  : a_pin, d_pin_out, d_pin_oe, rd_n, wr_n / d_pin_in, wait_n
// Build option: SM83_BUS_WAIT_EN lets wait_n=0 stretch T3 (see sm83_bus_seq);
// without it wait_n is ignored and every cycle is exactly four clocks.
module sm83_bus_ctl
  import sm83_bus_pkg::*;
#(
  parameter int ADR_WIDTH  = DEF_ADR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic           clk,
  input logic           reset,
  sm83_bus_ctl_if.slave bus
);

  tstate_t               state;
  logic                  load;
  logic                  ack;
  logic                  req;

  logic [ADR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  bus_dir_t              dir_q;

  logic                  in_cycle;
  logic                  is_rd;
  logic                  is_wr;
  logic                  data_phase;

  assign req = bus.req_rd | bus.req_wr;

  sm83_bus_seq u_seq (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .wait_n (bus.wait_n),
    .state  (state),
    .load   (load),
    .ack    (ack)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dir_q   <= RD;
    end else begin
      // Leaving T4 of a read: d_pin_in is taken on the same edge that may
      // load the next request, so the old direction is what matters here.
      if (state == T4 && dir_q == RD) begin
        rdata_q <= bus.d_pin_in;
      end
      if (load) begin
        addr_q  <= bus.adr_in;
        wdata_q <= bus.wdata;
        dir_q   <= req_dir(bus.req_rd, bus.req_wr);
      end
    end
  end

  assign in_cycle   = (state != IDLE);
  assign is_rd      = in_cycle & (dir_q == RD);
  assign is_wr      = in_cycle & (dir_q == WR);
  assign data_phase = (state == T2) | (state == T3) | (state == T4);

  // Pins decode straight from the state and capture registers; the address
  // register is never cleared between cycles so a_pin holds in IDLE.
  assign bus.a_pin     = addr_q;
  assign bus.d_pin_out = wdata_q;
  assign bus.d_pin_oe  = is_wr & data_phase;
  assign bus.rd_n      = ~is_rd;
  assign bus.wr_n      = ~(is_wr & (state == T3));

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack;
  assign bus.busy  = in_cycle;

endmodule
